// File: rtl/b_router.sv
// ---------------------------------------------------------------------------
// b_router
// Five-port bufferless deflection mesh router. Every cycle each valid input
// flit is given a distinct output: oldest first (ties to the lower input
// index), XY-productive direction when free, otherwise deflected to the
// lowest free mesh port. Outputs are registered, so latency is one clock.
//
// Parameters
//   X_COORD, Y_COORD : node coordinates (3 bits used)
// Ports
//   clk              : rising-edge clock
//   rst              : synchronous active-high reset
//   port{0..4}_ci    : input control word {valid, age[8:0], src[5:0], dest[5:0]}
//                      0=North 1=East 2=South 3=West 4=Local inject
//   port{0..4}_di    : input payload
//   port{0..4}_co    : registered output control word (port4 = eject)
//   port{0..4}_do    : registered output payload
//   port4_ready      : combinational; a local injection is accepted this cycle
// ---------------------------------------------------------------------------
module b_router #(
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [21:0]  port0_ci,
    input  logic [21:0]  port1_ci,
    input  logic [21:0]  port2_ci,
    input  logic [21:0]  port3_ci,
    input  logic [21:0]  port4_ci,
    input  logic [127:0] port0_di,
    input  logic [127:0] port1_di,
    input  logic [127:0] port2_di,
    input  logic [127:0] port3_di,
    input  logic [127:0] port4_di,
    output logic [21:0]  port0_co,
    output logic [21:0]  port1_co,
    output logic [21:0]  port2_co,
    output logic [21:0]  port3_co,
    output logic [21:0]  port4_co,
    output logic [127:0] port0_do,
    output logic [127:0] port1_do,
    output logic [127:0] port2_do,
    output logic [127:0] port3_do,
    output logic [127:0] port4_do,
    output logic         port4_ready
);

    localparam logic [2:0] MY_X = X_COORD[2:0];
    localparam logic [2:0] MY_Y = Y_COORD[2:0];

    // XY dimension-order routing: resolve x first, then y, else eject.
    function automatic logic [2:0] prod_port(input logic [5:0] dest);
        logic [2:0] p;
        if (dest[2:0] > MY_X) begin
            p = 3'd1;
        end else if (dest[2:0] < MY_X) begin
            p = 3'd3;
        end else if (dest[5:3] > MY_Y) begin
            p = 3'd2;
        end else if (dest[5:3] < MY_Y) begin
            p = 3'd0;
        end else begin
            p = 3'd4;
        end
        return p;
    endfunction

    // Age advances by one per hop and sticks at the maximum.
    function automatic logic [8:0] age_inc(input logic [8:0] age);
        return (age == 9'h1FF) ? 9'h1FF : age + 9'd1;
    endfunction

    logic [21:0]  ci_s [5];
    logic [127:0] di_s [5];
    logic [2:0]   prod_s [5];
    logic [2:0]   rank_s [5];
    logic [2:0]   sel_s [5];
    logic [4:0]   vld_s;
    logic [4:0]   used_s;
    logic [4:0]   free_s;
    logic         found_s;
    logic [2:0]   mesh_cnt_s;
    logic         any_eject_s;
    logic         ready_s;
    logic [21:0]  co_r [5];
    logic [127:0] do_r [5];

    assign ci_s[0] = port0_ci;
    assign ci_s[1] = port1_ci;
    assign ci_s[2] = port2_ci;
    assign ci_s[3] = port3_ci;
    assign ci_s[4] = port4_ci;
    assign di_s[0] = port0_di;
    assign di_s[1] = port1_di;
    assign di_s[2] = port2_di;
    assign di_s[3] = port3_di;
    assign di_s[4] = port4_di;

    // Productive output for every input flit.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            prod_s[i] = prod_port(ci_s[i][5:0]);
        end
    end

    // Injection is allowed only while a mesh port is certain to remain free
    // after every mesh flit (and at most one ejector) has been placed.
    always_comb begin
        mesh_cnt_s  = 3'd0;
        any_eject_s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mesh_cnt_s  = mesh_cnt_s + {2'b00, ci_s[i][21]};
            any_eject_s = any_eject_s | (ci_s[i][21] & (prod_s[i] == 3'd4));
        end
        ready_s = (mesh_cnt_s - {2'b00, any_eject_s}) < 3'd4;
    end

    assign port4_ready = ready_s;

    // Accepted flits; a local flit is dropped from consideration when not ready.
    always_comb begin
        vld_s[3:0] = {ci_s[3][21], ci_s[2][21], ci_s[1][21], ci_s[0][21]};
        vld_s[4]   = ci_s[4][21] & ready_s;
    end

    // Priority rank = number of accepted flits that beat this one
    // (older wins, equal age goes to the lower input index).
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            rank_s[i] = 3'd0;
            for (int j = 0; j < 5; j++) begin
                if ((j != i) && vld_s[j] &&
                    ((ci_s[j][20:12] > ci_s[i][20:12]) ||
                     ((ci_s[j][20:12] == ci_s[i][20:12]) && (j < i)))) begin
                    rank_s[i] = rank_s[i] + 3'd1;
                end else begin
                    rank_s[i] = rank_s[i];
                end
            end
        end
    end

    // Greedy allocation in rank order; sel_s[o] names the input feeding output o.
    always_comb begin
        free_s  = 5'b11111;
        used_s  = 5'b00000;
        found_s = 1'b0;
        for (int o = 0; o < 5; o++) begin
            sel_s[o] = 3'd0;
        end
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 5; i++) begin
                if (vld_s[i] && (rank_s[i] == 3'(r))) begin
                    if (free_s[prod_s[i]]) begin
                        // Covers both an ejector reaching output 4 and a
                        // mesh-bound flit reaching its productive port.
                        free_s[prod_s[i]] = 1'b0;
                        used_s[prod_s[i]] = 1'b1;
                        sel_s[prod_s[i]]  = 3'(i);
                    end else begin
                        // Deflect to the lowest free mesh port; never to eject.
                        found_s = 1'b0;
                        for (int k = 0; k < 4; k++) begin
                            if (!found_s && free_s[k]) begin
                                found_s   = 1'b1;
                                free_s[k] = 1'b0;
                                used_s[k] = 1'b1;
                                sel_s[k]  = 3'(i);
                            end else begin
                                found_s = found_s;
                            end
                        end
                    end
                end else begin
                    free_s = free_s;
                end
            end
        end
    end

    // Output registers: assigned flits advance with aged control words.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < 5; o++) begin
                co_r[o] <= 22'd0;
                do_r[o] <= 128'd0;
            end
        end else begin
            for (int o = 0; o < 5; o++) begin
                if (used_s[o]) begin
                    co_r[o] <= {1'b1, age_inc(ci_s[sel_s[o]][20:12]), ci_s[sel_s[o]][11:0]};
                    do_r[o] <= di_s[sel_s[o]];
                end else begin
                    co_r[o] <= 22'd0;
                    do_r[o] <= 128'd0;
                end
            end
        end
    end

    assign port0_co = co_r[0];
    assign port1_co = co_r[1];
    assign port2_co = co_r[2];
    assign port3_co = co_r[3];
    assign port4_co = co_r[4];
    assign port0_do = do_r[0];
    assign port1_do = do_r[1];
    assign port2_do = do_r[2];
    assign port3_do = do_r[3];
    assign port4_do = do_r[4];

endmodule

// File: tb/tb_b_router.sv
// ---------------------------------------------------------------------------
// tb_b_router
// Drives two routers (node (0,0) and node (3,4)) with the same inputs and
// checks every output against a reference model that sorts flits by age and
// hands out ports one by one.
// ---------------------------------------------------------------------------
module tb_b_router;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [21:0]  ci_t [5];
    logic [127:0] di_t [5];
    logic [21:0]  co_a [5];
    logic [127:0] do_a [5];
    logic         rdy_a;
    logic [21:0]  co_b [5];
    logic [127:0] do_b [5];
    logic         rdy_b;

    logic [21:0]  exp_co [2][5];
    logic [127:0] exp_do [2][5];
    logic         exp_rdy [2];

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] PAY = 128'h0123456789abcdef0123456789abcdef;

    always #5 clk = ~clk;

    b_router #(.X_COORD(0), .Y_COORD(0)) dut_a (
        .clk(clk), .rst(rst),
        .port0_ci(ci_t[0]), .port1_ci(ci_t[1]), .port2_ci(ci_t[2]),
        .port3_ci(ci_t[3]), .port4_ci(ci_t[4]),
        .port0_di(di_t[0]), .port1_di(di_t[1]), .port2_di(di_t[2]),
        .port3_di(di_t[3]), .port4_di(di_t[4]),
        .port0_co(co_a[0]), .port1_co(co_a[1]), .port2_co(co_a[2]),
        .port3_co(co_a[3]), .port4_co(co_a[4]),
        .port0_do(do_a[0]), .port1_do(do_a[1]), .port2_do(do_a[2]),
        .port3_do(do_a[3]), .port4_do(do_a[4]),
        .port4_ready(rdy_a)
    );

    b_router #(.X_COORD(3), .Y_COORD(4)) dut_b (
        .clk(clk), .rst(rst),
        .port0_ci(ci_t[0]), .port1_ci(ci_t[1]), .port2_ci(ci_t[2]),
        .port3_ci(ci_t[3]), .port4_ci(ci_t[4]),
        .port0_di(di_t[0]), .port1_di(di_t[1]), .port2_di(di_t[2]),
        .port3_di(di_t[3]), .port4_di(di_t[4]),
        .port0_co(co_b[0]), .port1_co(co_b[1]), .port2_co(co_b[2]),
        .port3_co(co_b[3]), .port4_co(co_b[4]),
        .port0_do(do_b[0]), .port1_do(do_b[1]), .port2_do(do_b[2]),
        .port3_do(do_b[3]), .port4_do(do_b[4]),
        .port4_ready(rdy_b)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: pick flits oldest-first (lower index on ties), give each its
    // wanted port if still unclaimed, else the lowest unclaimed mesh port.
    function automatic void model(input int inst, input int x, input int y, input logic rst_v);
        int  n;
        bit  ej;
        bit  rdy;
        bit  cand [5];
        bit  taken [5];
        int  best;
        int  want;
        int  outp;
        int  dx;
        int  dy;
        int  age;
        n  = 0;
        ej = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (ci_t[i][21]) begin
                n++;
                if (int'(ci_t[i][2:0]) == x && int'(ci_t[i][5:3]) == y) ej = 1'b1;
            end
        end
        rdy = (n - int'(ej)) < 4;
        exp_rdy[inst] = rdy;
        for (int o = 0; o < 5; o++) begin
            exp_co[inst][o] = 22'd0;
            exp_do[inst][o] = 128'd0;
            taken[o] = 1'b0;
            cand[o] = ci_t[o][21];
        end
        if (!rdy) cand[4] = 1'b0;
        if (rst_v) return;
        for (int step = 0; step < 5; step++) begin
            best = -1;
            for (int i = 0; i < 5; i++) begin
                if (cand[i] && (best < 0 || ci_t[i][20:12] > ci_t[best][20:12])) best = i;
            end
            if (best >= 0) begin
                cand[best] = 1'b0;
                dx = int'(ci_t[best][2:0]);
                dy = int'(ci_t[best][5:3]);
                if (dx > x) want = 1;
                else if (dx < x) want = 3;
                else if (dy > y) want = 2;
                else if (dy < y) want = 0;
                else want = 4;
                outp = -1;
                if (!taken[want]) outp = want;
                else begin
                    for (int k = 0; k < 4; k++) if (outp < 0 && !taken[k]) outp = k;
                end
                if (outp >= 0) begin
                    taken[outp] = 1'b1;
                    age = int'(ci_t[best][20:12]);
                    if (age < 511) age = age + 1;
                    exp_co[inst][outp] = {1'b1, 9'(age), ci_t[best][11:0]};
                    exp_do[inst][outp] = di_t[best];
                end
            end
        end
    endfunction

    // Check port4_ready before the edge and all outputs just after it.
    task automatic step(input logic rst_v, input string name);
        rst = rst_v;
        #1;
        model(0, 0, 0, rst_v);
        model(1, 3, 4, rst_v);
        chk($sformatf("%s rdy_a", name), {127'd0, rdy_a}, {127'd0, exp_rdy[0]});
        chk($sformatf("%s rdy_b", name), {127'd0, rdy_b}, {127'd0, exp_rdy[1]});
        @(posedge clk);
        #1;
        for (int o = 0; o < 5; o++) begin
            chk($sformatf("%s a.co%0d", name, o), {106'd0, co_a[o]}, {106'd0, exp_co[0][o]});
            chk($sformatf("%s a.do%0d", name, o), do_a[o], exp_do[0][o]);
            chk($sformatf("%s b.co%0d", name, o), {106'd0, co_b[o]}, {106'd0, exp_co[1][o]});
            chk($sformatf("%s b.do%0d", name, o), do_b[o], exp_do[1][o]);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 5; p++) begin
            ci_t[p] = 22'd0;
            di_t[p] = PAY;
        end
    endtask

    initial begin
        logic [8:0] age_v;
        logic [5:0] dst_v;

        // Reset with traffic present; ready still reflects four mesh flits.
        clear_inputs();
        for (int p = 0; p < 5; p++) ci_t[p] = 22'h200001;
        step(1'b1, "reset");
        chk("reset ready_low", {127'd0, rdy_a}, 128'd0);
        for (int o = 0; o < 5; o++) chk($sformatf("reset co%0d", o), {106'd0, co_a[o]}, 128'd0);

        // Contention at (0,0): three east-bound flits of equal age.
        clear_inputs();
        ci_t[0] = 22'h200001;
        ci_t[1] = 22'h200802;
        ci_t[2] = 22'h200c03;
        step(1'b0, "contend");
        chk("contend co1", {106'd0, co_a[1]}, {106'd0, 22'h201001});
        chk("contend co0", {106'd0, co_a[0]}, {106'd0, 22'h201802});
        chk("contend co2", {106'd0, co_a[2]}, {106'd0, 22'h201c03});
        chk("contend co3", {106'd0, co_a[3]}, 128'd0);
        chk("contend co4", {106'd0, co_a[4]}, 128'd0);
        chk("contend do0", do_a[0], PAY);
        chk("contend do1", do_a[1], PAY);
        chk("contend do2", do_a[2], PAY);

        ci_t[0] = 22'd0;
        step(1'b0, "contend2");
        chk("contend2 co1", {106'd0, co_a[1]}, {106'd0, 22'h201802});
        chk("contend2 co0", {106'd0, co_a[0]}, {106'd0, 22'h201c03});
        chk("contend2 co2", {106'd0, co_a[2]}, 128'd0);

        // Age priority: older west-port flit wins east.
        clear_inputs();
        ci_t[3] = {1'b1, 9'd5, 6'h07, 6'h01};
        ci_t[0] = {1'b1, 9'd0, 6'h05, 6'h01};
        di_t[3] = 128'h33;
        di_t[0] = 128'h11;
        step(1'b0, "age");
        chk("age co1", {106'd0, co_a[1]}, {106'd0, 1'b1, 9'd6, 6'h07, 6'h01});
        chk("age co0", {106'd0, co_a[0]}, {106'd0, 1'b1, 9'd1, 6'h05, 6'h01});
        chk("age do1", do_a[1], 128'h33);

        // Ejection plus injection.
        clear_inputs();
        ci_t[0] = 22'h200041;
        ci_t[1] = 22'h200082;
        ci_t[2] = 22'h2000C0;
        ci_t[3] = 22'h200103;
        ci_t[4] = 22'h200145;
        step(1'b0, "eject");
        chk("eject co4", {106'd0, co_a[4]}, {106'd0, 22'h2010C0});
        chk("eject co1", {106'd0, co_a[1]}, {106'd0, 22'h201041});
        chk("eject co0", {106'd0, co_a[0]}, {106'd0, 22'h201082});
        chk("eject co2", {106'd0, co_a[2]}, {106'd0, 22'h201103});
        chk("eject co3", {106'd0, co_a[3]}, {106'd0, 22'h201145});

        // Age saturation.
        clear_inputs();
        ci_t[0] = 22'h3FF001;
        step(1'b0, "sat");
        chk("sat co1", {106'd0, co_a[1]}, {106'd0, 22'h3FF001});

        // Full: four mesh flits block injection.
        clear_inputs();
        for (int p = 0; p < 4; p++) ci_t[p] = {1'b1, 9'(p), 6'(p), 6'h01};
        ci_t[4] = {1'b1, 9'h1FF, 6'h3F, 6'h01};
        step(1'b0, "full");
        chk("full co4", {106'd0, co_a[4]}, 128'd0);
        chk("full co1", {106'd0, co_a[1]}, {106'd0, 1'b1, 9'd4, 6'd3, 6'h01});

        // Reset mid-operation discards the registered flits.
        step(1'b0, "pre_rst");
        step(1'b1, "mid_rst");
        chk("mid_rst co1", {106'd0, co_a[1]}, 128'd0);

        // Randomised traffic, biased toward age ties, saturation and ejection.
        for (int it = 0; it < 400; it++) begin
            for (int p = 0; p < 5; p++) begin
                age_v = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(509, 511))
                                                    : 9'($urandom_range(0, 3));
                dst_v = 6'($urandom);
                if ($urandom_range(0, 4) == 0) dst_v = (it % 2 == 0) ? 6'h00 : 6'h23;
                ci_t[p] = {1'($urandom_range(0, 3) != 0), age_v, 6'($urandom), dst_v};
                di_t[p] = {$urandom, $urandom, $urandom, $urandom};
            end
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, $sformatf("rnd%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
